// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 demux: channel count, select width, slot state, select check.
// Pure definitions; no latency or backpressure of its own.
package demux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_t;

  // X/Z on either select bit marks the word as unroutable; synthesis folds this to 1.
  function automatic bit sel_known(input logic [SEL_W-1:0] sel);
    return !$isunknown(sel);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry output holding slot: fill lands in 1 cycle, stays until downstream takes it.
// Backpressure: slot_ready when empty or draining this cycle, so a full slot can be refilled.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             slot_ready
);

  chan_state_t state_q, state_d;
  logic        drain;

  assign out_valid  = (state_q == CH_FULL);
  assign drain      = out_valid && out_ready;
  assign slot_ready = (state_q == CH_EMPTY) || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CH_EMPTY;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      if (fill) out_data <= fill_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_EMPTY: if (fill)           state_d = CH_FULL;
      CH_FULL:  if (drain && !fill) state_d = CH_EMPTY;
      default:                      state_d = CH_EMPTY;
    endcase
  end

endmodule

// File: rtl/demux1to4_buf.sv
// Registered 1-to-4 demux with per-channel valid/ready slots; accepted word is visible next cycle.
// Backpressure: in_ready follows the selected slot; unknown selects are always taken and dropped.
module demux1to4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  s1,
  input  logic                  s0,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic                  err_sel,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      acc_cnt
);

  logic [SEL_W-1:0] sel;
  logic             sel_ok;
  logic             drop;
  logic [N_CH-1:0]  fill;
  logic [N_CH-1:0]  slot_ready;

  assign sel      = {s1, s0};
  assign sel_ok   = sel_known(sel);
  assign in_ready = sel_ok ? slot_ready[sel] : 1'b1;
  assign drop     = in_valid && !sel_ok;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign fill[k] = in_valid && in_ready && sel_ok && (sel == SEL_W'(k));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .fill      (fill[k]),
      .fill_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .slot_ready(slot_ready[k])
    );
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
      acc_cnt  <= '0;
    end else begin
      err_sel <= drop;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      if ((|fill) && (acc_cnt != '1)) acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux1to4_buf.sv
// Randomized scoreboard bench for demux1to4_buf: per-channel expected queues, monitor pops on drain.
module tb_demux1to4_buf;

  localparam int W   = 8;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            s1, s0;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [4*W-1:0]  out_data;
  logic            err_sel;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   acc_cnt;

  demux1to4_buf #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .s1(s1), .s0(s0), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_sel(err_sel),
    .drop_cnt(drop_cnt), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q [4][$];
  int  drains [4];
  int  m_acc  = 0;
  int  m_drop = 0;
  bit  exp_err = 1'b0;
  bit  acc_flag;
  bit  x_ok;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Monitor: a full slot must hold the oldest outstanding word for that channel.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(exp_q[k].size() != 0));
        if (out_valid[k] && exp_q[k].size() != 0) begin
          check($sformatf("out_data[%0d]", k), 64'(out_data[k*W +: W]), 64'(exp_q[k][0]));
          if (out_ready[k]) begin
            void'(exp_q[k].pop_front());
            drains[k]++;
          end
        end
      end
    end
  end

  // One clock cycle: check sideband outputs, record what the upcoming edge accepts.
  task automatic step();
    @(negedge clk);
    #1;
    acc_flag = 1'b0;
    if (rst_n) begin
      check("err_sel", 64'(err_sel), 64'(exp_err));
      check("acc_cnt", 64'(acc_cnt), 64'(sat(m_acc)));
      check("drop_cnt", 64'(drop_cnt), 64'(sat(m_drop)));
    end
    exp_err = 1'b0;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
      m_acc  = 0;
      m_drop = 0;
    end else if (in_valid && in_ready) begin
      acc_flag = 1'b1;
      if ($isunknown({s1, s0})) begin
        m_drop++;
        exp_err = 1'b1;
      end else begin
        exp_q[int'({s1, s0})].push_back(in_data);
        m_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic rand_sel_bit();
    int r;
    logic b;
    r = $urandom_range(0, 19);
    if (r == 0)      b = 1'bx;
    else if (r == 1) b = 1'bz;
    else             b = 1'($urandom_range(0, 1));
    return b;
  endfunction

  initial begin
    logic probe;
    logic [3:0] prev_v;
    int d0, words, cyc;

    probe = 1'bx;
    x_ok  = $isunknown(probe);
    for (int k = 0; k < 4; k++) drains[k] = 0;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; s1 = 1'b0; s0 = 1'b0; out_ready = '0;
    step(); step();
    rst_n = 1'b1;
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data", 64'(out_data), 64'h0);

    // Mid-operation reset with channel 3 full and blocked.
    in_valid = 1'b1; {s1, s0} = 2'b11; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    check("ch3 full before reset", 64'(out_valid), 64'b1000);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst out_valid", 64'(out_valid), 64'h0);
    check("rst out_data", 64'(out_data), 64'h0);
    check("rst counters", 64'({acc_cnt, drop_cnt, 7'd0, err_sel}), 64'h0);
    in_valid = 1'b1; {s1, s0} = 2'b11; in_data = 8'h01;
    step();
    in_valid = 1'b0;
    check("post-reset fill valid", 64'(out_valid), 64'b1000);
    check("post-reset fill data", 64'(out_data[3*W +: W]), 64'h01);
    out_ready = 4'b1000; step(); out_ready = '0;

    // Basic routing to channel 2, held under backpressure.
    in_valid = 1'b1; {s1, s0} = 2'b10; in_data = 8'h01;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("route valid", 64'(out_valid), 64'b0100);
      check("route data", 64'(out_data[2*W +: W]), 64'h01);
      step();
    end
    {s1, s0} = 2'b10; #1;
    check("in_ready full ch2", 64'(in_ready), 64'h0);
    {s1, s0} = 2'b00; #1;
    check("in_ready empty ch0", 64'(in_ready), 64'h1);
    out_ready = 4'b0100; step(); out_ready = '0;

    // Pass-through: drain and refill channel 1 in the same cycle.
    d0 = drains[1];
    in_valid = 1'b1; {s1, s0} = 2'b01; in_data = 8'h01;
    step();
    in_data = 8'h00; out_ready = 4'b0010; #1;
    check("pass in_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0; out_ready = '0;
    check("pass valid", 64'(out_valid[1]), 64'h1);
    check("pass data", 64'(out_data[1*W +: W]), 64'h00);
    out_ready = 4'b0010; step(); out_ready = '0;
    step();
    check("pass drains", 64'(drains[1] - d0), 64'd2);

    // Unknown select: consumed, dropped, one-cycle error pulse.
    in_valid = 1'b1; s1 = 1'b1; s0 = 1'bx; in_data = 8'hC3; #1;
    check("unknown in_ready", 64'(in_ready), 64'h1);
    prev_v = out_valid;
    step();
    in_valid = 1'b0; s0 = 1'b0;
    if (x_ok) check("unknown out_valid", 64'(out_valid), 64'(prev_v));
    out_ready = '1; step(); step(); out_ready = '0;

    // Ignored inputs while in_valid is low.
    prev_v = out_valid;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b0; s1 = 1'bx; in_data = 'x;
      step();
    end
    check("idle out_valid", 64'(out_valid), 64'(prev_v));
    s1 = 1'b0; in_data = '0;

    // Saturate the drop counter.
    out_ready = '1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; s1 = 1'bx; s0 = 1'($urandom_range(0, 1)); in_data = W'($urandom);
      step();
    end
    in_valid = 1'b0; s1 = 1'b0;
    step(); step();
    if (x_ok) check("drop_cnt saturated", 64'(drop_cnt), 64'(SAT));

    // Random traffic with randomized downstream readiness.
    words = 0; cyc = 0;
    while (words < 2000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      s1        = rand_sel_bit();
      s0        = rand_sel_bit();
      in_data   = in_valid ? W'($urandom) : 'x;
      out_ready = 4'($urandom);
      step();
      if (acc_flag) words++;
      cyc++;
    end
    if (words < 2000) begin
      n_tests++; n_fail++;
      $display("FAIL random budget: got %0d words expected 2000", words);
    end
    in_valid = 1'b0; s1 = 1'b0; s0 = 1'b0; out_ready = '1;
    step(); step(); step();
    for (int k = 0; k < 4; k++)
      check($sformatf("final queue[%0d]", k), 64'(exp_q[k].size()), 64'd0);
    check("final acc_cnt", 64'(acc_cnt), 64'(sat(m_acc)));
    check("final drop_cnt", 64'(drop_cnt), 64'(sat(m_drop)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1to4_buf.md
Name: demux1to4_buf

Overview:
- Registered 1-to-4 demultiplexer: the distribution end of the 4:1 select interface used by mux4to1.
- Accepts one data word per handshake with a 2-bit select (s1,s0) and routes it into one of four single-entry output holding slots.
- Each output channel has its own valid/ready handshake toward downstream.
- Unknown select values (X/Z) are dropped and counted, matching the four-state stimulus (`inject()` distribution) used across this test pack.

Parameters:
- WIDTH, 1: data word width per channel.
- CNT_W, 8: width of the saturating drop and accept counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  upstream word accepted when in_valid && in_ready.
- in_data  in  WIDTH  upstream word.
- s1  in  1  select MSB, qualified by in_valid.
- s0  in  1  select LSB, qualified by in_valid.
- out_valid  out  4  per-channel slot full; bit k means channel k.
- out_ready  in  4  per-channel downstream ready.
- out_data  out  4*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- err_sel  out  1  one-cycle pulse: word dropped due to unknown select.
- drop_cnt  out  CNT_W  saturating count of dropped words.
- acc_cnt  out  CNT_W  saturating count of words delivered into slots.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-low, rst_n. No asynchronous reset paths.
- Reset (rst_n low at a clk edge), including mid-operation: all slots go CH_EMPTY, out_valid=0, out_data=0, err_sel=0, drop_cnt=0, acc_cnt=0. Words held in slots at reset are discarded.
- sel = {s1,s0}. "Known" means no bit is X/Z, tested with four-state compare in simulation. Synthesis sees sel as always known.
- Per-channel FSM, two states:
  - CH_EMPTY -> CH_FULL on fill.
  - CH_FULL -> CH_EMPTY on drain without fill.
  - CH_FULL -> CH_FULL on drain with fill (slot data replaced).
- Fill of channel k = in_valid && in_ready && known sel && sel==k.
- Drain of channel k = out_valid[k] && out_ready[k].
- in_ready, combinational:
  - sel known: ~full[sel] | out_ready[sel]. Pass-through allowed, so a full slot can be drained and refilled in the same cycle.
  - sel unknown: 1.
- in_ready depends on the s1/s0/out_ready inputs only, never on in_valid.
- Latency: word accepted in cycle t appears on out_valid/out_data at cycle t+1.
- out_data[k] holds stable while out_valid[k]=1 and not drained. On an empty slot it keeps its last value (0 after reset).
- Unknown sel with in_valid=1: word consumed, no slot changes. err_sel=1 in the next cycle only; drop_cnt increments.
- Counters saturate at 2^CNT_W-1 and never wrap. acc_cnt increments once per fill.
- Fills on different channels in different cycles are independent. Only one fill per cycle is possible.
- Simultaneous fill/drain on different channels: both take effect.
- in_valid=0: no state change except drains; s1/s0/in_data are ignored even if X.

Decomposition:
- Package demux_pkg holds:
  - N_CH=4 and SEL_W=2.
  - Enum chan_state_t {CH_EMPTY, CH_FULL}.
  - Function sel_known(logic [1:0]) returning bit (four-state check).
- Sub-module demux_slot:
  - One-entry holding register with the CH_EMPTY/CH_FULL FSM.
  - Ports: clk, rst_n, fill, fill_data, out_ready, out_valid, out_data, slot_ready.
  - Instantiated 4x via generate.
- Top level: select decode, in_ready mux, err_sel register, both counters.

Test Plan:
- Reset: rst_n low 2 cycles while ch3 full and out_ready=0 -> next cycle out_valid=4'b0000, out_data=0, counters 0. A following fill to sel=2'b11, data=1 appears at t+1.
- Basic routing: sel=2'b10, in_data=1, in_valid for 1 cycle, out_ready=0 ->
  - out_valid=4'b0100 and out_data[2]=1 from t+1, held 5 cycles.
  - in_ready=0 for sel=2'b10, 1 for sel=2'b00.
  - acc_cnt=1.
- Pass-through: ch1 full with data 1, out_ready[1]=1, in_valid with sel=2'b01, data=0 ->
  - in_ready=1 in the same cycle.
  - out_valid[1] stays 1; out_data[1]=0 next cycle.
  - Exactly two drains are observed in total.
- Unknown select: {s1,s0}=2'b1x, in_valid=1 ->
  - in_ready=1; out_valid unchanged.
  - err_sel=1 for exactly one cycle; drop_cnt 0->1.
  - After 300 such words with CNT_W=8, drop_cnt=255.
- X tolerance: in_valid=0 with s1=x, in_data=x for 10 cycles -> no state change, err_sel=0, counters unchanged.
- Random: 2000 words from the inject() distribution, out_ready randomized -> per-channel scoreboard queues match in order. Only unknown-select words are missing, and their count equals drop_cnt.
